// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-style multiplier, RNE, flush-to-zero.
// Ports: clk/rst, in_valid/in_ready + a/b, out_valid/out_ready + result/flags.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;

  localparam logic [EW-1:0] BIAS =
    EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_OVF =
    EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CL_NUM,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } cls_e;

  typedef struct packed {
    logic              sign;
    logic [EW-1:0]     e;
    logic [MW-1:0]     ma;
    logic [MW-1:0]     mb;
    cls_e              cls;
    logic              inv;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [EW-1:0]     e;
    logic [PW-1:0]     p;
    cls_e              cls;
    logic              inv;
  } s2_t;

  logic en;
  logic v1, v2, v3;
  s1_t  s1, s1_d;
  s2_t  s2, s2_d;

  logic [W-1:0] res_d;
  logic [3:0]   flg_d;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  // stage 1: unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb;
  logic sna, snb, inf_zero;

  assign ea = a[MAN_W +: EXP_W];
  assign eb = b[MAN_W +: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  // subnormals (exp==0) are treated as zero
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == EMAX) && (fa == '0);
  assign ib = (eb == EMAX) && (fb == '0);
  assign na = (ea == EMAX) && (fa != '0);
  assign nb = (eb == EMAX) && (fb != '0);

  // signalling NaN has the fraction MSB clear
  assign sna      = na && !fa[MAN_W-1];
  assign snb      = nb && !fb[MAN_W-1];
  assign inf_zero = (ia && zb) || (za && ib);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = a[W-1] ^ b[W-1];
    s1_d.e    = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.ma   = {1'b1, fa};
    s1_d.mb   = {1'b1, fb};
    s1_d.inv  = inf_zero || sna || snb;
    if (na || nb || inf_zero) begin
      s1_d.cls = CL_NAN;
    end else if (ia || ib) begin
      s1_d.cls = CL_INF;
    end else if (za || zb) begin
      s1_d.cls = CL_ZERO;
    end else begin
      s1_d.cls = CL_NUM;
    end
  end

  // stage 2: mantissa product
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1.sign;
    s2_d.e    = s1.e;
    s2_d.p    = PW'(s1.ma) * PW'(s1.mb);
    s2_d.cls  = s1.cls;
    s2_d.inv  = s1.inv;
  end

  // stage 3: normalise, round, pack
  logic [PW-1:0]           pn;
  logic [MW-1:0]           kept;
  logic                    g, st, inc;
  logic [MW:0]             rnd;
  logic signed [EW-1:0]    e_f;
  logic [MAN_W-1:0]        frac;

  // product of two [1,2) mantissas lies in [1,4): at most one shift
  assign pn   = s2.p[PW-1] ? s2.p : {s2.p[PW-2:0], 1'b0};
  assign kept = pn[PW-1 -: MW];
  assign g    = pn[MAN_W];
  assign st   = |pn[MAN_W-1:0];
  assign inc  = g && (st || kept[0]);
  assign rnd  = {1'b0, kept} + {{MW{1'b0}}, inc};

  // a rounding carry leaves 10..0, so the fraction is rnd[MAN_W:1]
  assign e_f  = s2.e + EW'(s2.p[PW-1]) + EW'(rnd[MW]);
  assign frac = rnd[MW] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (s2.cls)
      CL_NAN: begin
        res_d = QNAN;
        flg_d = {s2.inv, 3'b000};
      end
      CL_INF: begin
        res_d = {s2.sign, EMAX, {MAN_W{1'b0}}};
      end
      CL_ZERO: begin
        res_d = {s2.sign, {(W-1){1'b0}}};
      end
      default: begin
        if (e_f >= E_OVF) begin
          res_d = {s2.sign, EMAX, {MAN_W{1'b0}}};
          flg_d = 4'b0101;
        end else if (e_f <= E_ZERO) begin
          res_d = {s2.sign, {(W-1){1'b0}}};
          flg_d = 4'b0011;
        end else begin
          res_d = {s2.sign, e_f[EXP_W-1:0], frac};
          flg_d = {3'b000, g || st};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      result <= '0;
      flags  <= '0;
    end else if (en) begin
      v1     <= in_valid;
      s1     <= s1_d;
      v2     <= v1;
      s2     <= s2_d;
      v3     <= v2;
      result <= res_d;
      flags  <= flg_d;
    end
  end

endmodule
